sram_ctrl: RTL and testbench
============================

// Module: sram_ctrl
// PURPOSE
//  Synchronous master for an external async SRAM (ceb/web/oeb, shared inout data, addr).
//  Converts a single-clock valid/ready command port into correctly sequenced SRAM cycles.
//  Sits between imager frame-buffer logic and the SRAM pins; pairs with the sim sram model.
//  One access in flight at a time; every pin output is driven straight from a flop.
// PARAMETERS
//  ADDR_WIDTH  18  SRAM address width
//  DATA_WIDTH  16  SRAM data width
//  WR_CYCLES    2  clocks web held low per write (>=1)
//  RD_CYCLES    2  clocks ceb/oeb held low before read data is sampled (>=1)
// PORTS
//  clk         in     1           system clock; all logic on rising edge
//  reset       in     1           asynchronous, active-high reset
//  cmd_valid   in     1           command request
//  cmd_ready   out    1           controller idle; command accepted when valid&&ready
//  cmd_we      in     1           1=write, 0=read; sampled at accept
//  cmd_addr    in     ADDR_WIDTH  word address; sampled at accept
//  cmd_wdata   in     DATA_WIDTH  write data; sampled at accept
//  rdata       out    DATA_WIDTH  read result; holds until next read completes
//  rdata_valid out    1           one-cycle pulse when rdata updates
//  sram_ceb    out    1           SRAM chip enable, active low
//  sram_web    out    1           SRAM write enable, active low
//  sram_oeb    out    1           SRAM output enable, active low
//  sram_addr   out    ADDR_WIDTH  SRAM address
//  sram_data   inout  DATA_WIDTH  SRAM data; driven only when internal data_oe=1, else 'z
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, ceb=web=oeb=1, sram_addr=0, data_oe=0 (bus 'z),
//   rdata=0, rdata_valid=0, cmd_ready=1. Reset mid-write may truncate the web pulse; content
//   at that address is then undefined, no other address is affected.
//  States: IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_WAIT. cmd_ready=1 only in IDLE.
//  Accept edge E0 (IDLE, cmd_valid=1): latch addr/wdata into sram_addr / data register.
//  Write: WR_SETUP 1 clk: ceb=0, web=1, oeb=1, data_oe=1.
//   WR_PULSE WR_CYCLES clks: web=0, addr/data stable.
//   WR_HOLD 1 clk: web=1, ceb=0, data_oe=1 (data held past web rising edge).
//   Then IDLE: ceb=1, data_oe=0. Total busy = WR_CYCLES+2 clks; next accept on following edge.
//  Read: RD_WAIT RD_CYCLES clks: ceb=0, oeb=0, web=1, data_oe=0.
//   Edge ending last RD_WAIT clk: rdata<=sram_data, rdata_valid=1 (next clk only), ->IDLE
//   with ceb=oeb=1. Busy = RD_CYCLES clks; rdata_valid coincides with cmd_ready returning to 1.
//  Counter: single down-counter, width $clog2(max(WR_CYCLES,RD_CYCLES))+1, loaded at phase
//   entry, phase exits when it reaches 0; no wrap possible.
//  Invariants (every cycle): never (oeb==0 && data_oe==1); never (web==0 && oeb==0);
//   web==0 implies ceb==0; sram_addr changes only in IDLE/at accept with ceb==1 or at E0.
//  cmd_valid held while busy: ignored, no side effects; taken on first IDLE cycle.
//  cmd_valid and reset together: reset wins, command not accepted.
//  sram_addr retains last value in IDLE (no toggling); address wrap is the caller's concern.
// TESTING (bench = sram_ctrl + sram sim model, WR_CYCLES=RD_CYCLES=2)
//  Write 0x1234 @0x00010, read @0x00010 -> rdata=0x1234, rdata_valid 1 clk, 2 clks after accept.
//  Write 0xBEEF @0x3FFFF then 0x0001 @0x00000, read both -> 0xBEEF, 0x0001 (address extremes).
//  cmd_valid held high with 4 back-to-back writes -> cmd_ready low 4 clks each, 4 accepts, data ok.
//  Write immediately followed by read of same addr -> no cycle with oeb=0 and data_oe=1; 'x-free bus.
//  Assert reset during WR_PULSE -> ceb/web/oeb=1, bus 'z same cycle; cmd_ready=1 after release.
//  Sweep WR_CYCLES/RD_CYCLES in {1,4} -> web low exactly WR_CYCLES clks, oeb low RD_CYCLES clks.

Source files
------------

// File: rtl/sram_ctrl_if.sv
// Command port of the SRAM controller: valid/ready request plus read-result return.
interface sram_ctrl_if #(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_we;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rdata_valid;

  // Requester side (frame-buffer logic or testbench).
  modport master (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata,
    input  cmd_ready, rdata, rdata_valid
  );

  // Controller side.
  modport slave (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata,
    output cmd_ready, rdata, rdata_valid
  );
endinterface

// File: rtl/sram_ctrl.sv
// Synchronous master for an external asynchronous SRAM. One access in flight;
// every SRAM pin and every command-port output comes straight from a flop.
module sram_ctrl #(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 16,
  parameter int WR_CYCLES  = 2,
  parameter int RD_CYCLES  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  sram_ctrl_if.slave            cmd,
  output logic                  sram_ceb,
  output logic                  sram_web,
  output logic                  sram_oeb,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  inout  wire  [DATA_WIDTH-1:0] sram_data
);

  localparam int MAX_CYCLES = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    RD_WAIT
  } state_t;

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  ceb_q;
  logic                  web_q;
  logic                  oeb_q;
  logic                  data_oe_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rdata_valid_q;
  logic                  ready_q;

  assign sram_ceb        = ceb_q;
  assign sram_web        = web_q;
  assign sram_oeb        = oeb_q;
  assign sram_addr       = addr_q;
  assign sram_data       = data_oe_q ? wdata_q : 'z;
  assign cmd.cmd_ready   = ready_q;
  assign cmd.rdata       = rdata_q;
  assign cmd.rdata_valid = rdata_valid_q;

  // Access sequencer: pin levels are set one edge ahead of the phase they belong to,
  // so the cycle counter is loaded with N-1 and a phase ends on the edge it reads 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      ceb_q         <= 1'b1;
      web_q         <= 1'b1;
      oeb_q         <= 1'b1;
      data_oe_q     <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      ready_q       <= 1'b1;
    end else begin
      rdata_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd.cmd_valid) begin
            addr_q  <= cmd.cmd_addr;
            wdata_q <= cmd.cmd_wdata;
            ceb_q   <= 1'b0;
            ready_q <= 1'b0;
            if (cmd.cmd_we) begin
              data_oe_q <= 1'b1;
              state_q   <= WR_SETUP;
            end else begin
              oeb_q   <= 1'b0;
              cnt_q   <= RD_LOAD;
              state_q <= RD_WAIT;
            end
          end
        end
        WR_SETUP: begin
          web_q   <= 1'b0;
          cnt_q   <= WR_LOAD;
          state_q <= WR_PULSE;
        end
        WR_PULSE: begin
          if (cnt_q == '0) begin
            web_q   <= 1'b1;
            state_q <= WR_HOLD;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        WR_HOLD: begin
          ceb_q     <= 1'b1;
          data_oe_q <= 1'b0;
          ready_q   <= 1'b1;
          state_q   <= IDLE;
        end
        RD_WAIT: begin
          if (cnt_q == '0) begin
            rdata_q       <= sram_data;
            rdata_valid_q <= 1'b1;
            ceb_q         <= 1'b1;
            oeb_q         <= 1'b1;
            ready_q       <= 1'b1;
            state_q       <= IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Randomised scoreboard bench for sram_ctrl with an async SRAM model.
module tb_sram_ctrl;
  localparam int AW  = 18;
  localparam int DW  = 16;
  localparam int WRC = 2;
  localparam int RDC = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Main DUT and SRAM model
  sram_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) cif ();
  logic          ceb, web, oeb;
  logic [AW-1:0] saddr;
  wire  [DW-1:0] sdata;

  sram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WR_CYCLES(WRC), .RD_CYCLES(RDC)) dut (
    .clk(clk), .reset(reset), .cmd(cif.slave),
    .sram_ceb(ceb), .sram_web(web), .sram_oeb(oeb), .sram_addr(saddr), .sram_data(sdata)
  );

  bit [DW-1:0] mem [0:(1<<AW)-1];
  assign sdata = (!ceb && !oeb) ? mem[saddr] : 'z;
  always @(negedge clk) if (!ceb && !web) mem[saddr] <= sdata;

  // Timing-sweep instances; their SRAM returns a fixed address pattern
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return a[DW-1:0] ^ 16'h5A5A;
  endfunction

  sram_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) sif_a ();
  logic a_ceb, a_web, a_oeb; logic [AW-1:0] a_addr; wire [DW-1:0] a_data;
  sram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WR_CYCLES(1), .RD_CYCLES(4)) sw_a (
    .clk(clk), .reset(reset), .cmd(sif_a.slave),
    .sram_ceb(a_ceb), .sram_web(a_web), .sram_oeb(a_oeb), .sram_addr(a_addr), .sram_data(a_data)
  );
  assign a_data = (!a_ceb && !a_oeb) ? pat(a_addr) : 'z;

  sram_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) sif_b ();
  logic b_ceb, b_web, b_oeb; logic [AW-1:0] b_addr; wire [DW-1:0] b_data;
  sram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WR_CYCLES(4), .RD_CYCLES(1)) sw_b (
    .clk(clk), .reset(reset), .cmd(sif_b.slave),
    .sram_ceb(b_ceb), .sram_web(b_web), .sram_oeb(b_oeb), .sram_addr(b_addr), .sram_data(b_data)
  );
  assign b_data = (!b_ceb && !b_oeb) ? pat(b_addr) : 'z;

  // Reference memory: plain array semantics; unknown[] marks addresses a reset may have corrupted
  logic [DW-1:0] ref_mem [int];
  bit            unknown [int];

  typedef struct {
    logic [DW-1:0] data;
    bit            chk;
    int            due;
  } exp_t;
  exp_t exp_q[$];

  task automatic fail(input string nm, input logic [63:0] act, input logic [63:0] exp);
    errors++;
    $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) fail(nm, act, exp);
  endtask

  task automatic run_chk(input string nm, input logic low, inout int cnt, input int want);
    if (low) cnt++;
    else if (cnt != 0) begin
      check(nm, cnt, want);
      cnt = 0;
    end
  endtask

  // Scoreboard monitor: accepts update the reference, rdata_valid pops and compares
  int            busy_run = 0;
  int            exp_run  = 0;
  logic [AW-1:0] prev_addr = '0;
  logic          prev_ceb  = 1'b1;
  initial begin
    exp_t e;
    int   a;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        busy_run  = 0;
        prev_addr = saddr;
        prev_ceb  = ceb;
      end else begin
        if (cif.rdata_valid) begin
          checks++;
          if (exp_q.size() == 0) fail("rdata_valid_unexpected", 1, 0);
          else begin
            e = exp_q.pop_front();
            if (e.chk && cif.rdata !== e.data) fail("rdata", cif.rdata, e.data);
            check("rdata_latency", cyc, e.due);
          end
        end
        if (!cif.cmd_ready) busy_run++;
        else if (busy_run != 0) begin
          check("busy_clocks", busy_run, exp_run);
          busy_run = 0;
        end
        checks++;
        if ((!oeb && dut.data_oe_q) || (!web && !oeb) || (!web && ceb))
          fail("pin_invariant", {ceb, web, oeb, dut.data_oe_q}, 4'b0101);
        if (saddr != prev_addr && !prev_ceb) fail("addr_change_while_active", saddr, prev_addr);
        prev_addr = saddr;
        prev_ceb  = ceb;
        if (cif.cmd_valid && cif.cmd_ready) begin
          a = int'(cif.cmd_addr);
          if (cif.cmd_we) begin
            ref_mem[a] = cif.cmd_wdata;
            unknown.delete(a);
            exp_run = WRC + 2;
          end else begin
            e.data = ref_mem.exists(a) ? ref_mem[a] : '0;
            e.chk  = !unknown.exists(a);
            e.due  = cyc + RDC + 1;
            exp_q.push_back(e);
            exp_run = RDC;
          end
        end
      end
    end
  end

  // Pulse-width monitors on all three instances
  int m_wl = 0, m_ol = 0, a_wl = 0, a_ol = 0, b_wl = 0, b_ol = 0;
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      run_chk("main_web_low", !web,   m_wl, WRC);
      run_chk("main_oeb_low", !oeb,   m_ol, RDC);
      run_chk("swa_web_low",  !a_web, a_wl, 1);
      run_chk("swa_oeb_low",  !a_oeb, a_ol, 4);
      run_chk("swb_web_low",  !b_web, b_wl, 4);
      run_chk("swb_oeb_low",  !b_oeb, b_ol, 1);
    end else begin
      m_wl = 0; m_ol = 0;
    end
  end

  // Present a command (caller sits just after a rising edge); returns just after the accept edge
  task automatic issue(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit hold);
    int n = 0;
    cif.cmd_valid = 1'b1;
    cif.cmd_we    = we;
    cif.cmd_addr  = a;
    cif.cmd_wdata = d;
    do begin @(negedge clk); n++; end while (!cif.cmd_ready && n < 100);
    if (!cif.cmd_ready) begin checks++; fail("accept_timeout", 0, 1); end
    @(posedge clk); #1;
    if (!hold) cif.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !cif.cmd_ready) && n < 200) begin @(negedge clk); n++; end
    check("drain", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic sweep_op(input bit sel, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int   n = 0;
    logic rdy, rv;
    logic [DW-1:0] rd;
    if (sel) begin sif_b.cmd_valid = 1'b1; sif_b.cmd_we = we; sif_b.cmd_addr = a; sif_b.cmd_wdata = d; end
    else     begin sif_a.cmd_valid = 1'b1; sif_a.cmd_we = we; sif_a.cmd_addr = a; sif_a.cmd_wdata = d; end
    do begin
      @(negedge clk); n++;
      rdy = sel ? sif_b.cmd_ready : sif_a.cmd_ready;
    end while (!rdy && n < 100);
    if (!rdy) begin checks++; fail("sweep_accept_timeout", 0, 1); end
    @(posedge clk); #1;
    sif_a.cmd_valid = 1'b0;
    sif_b.cmd_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk); n++;
      rdy = sel ? sif_b.cmd_ready : sif_a.cmd_ready;
      rv  = sel ? sif_b.rdata_valid : sif_a.rdata_valid;
      rd  = sel ? sif_b.rdata : sif_a.rdata;
    end while (!rdy && n < 20);
    check("sweep_idle_return", rdy, 1);
    if (!we) begin
      check("sweep_rdata_valid", rv, 1);
      check("sweep_rdata", rd, pat(a));
    end
    @(posedge clk); #1;
  endtask

  // Global time bound
  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Stimulus
  logic [AW-1:0] pool [16];
  initial begin
    int n;
    cif.cmd_valid = 1'b0; cif.cmd_we = 1'b0; cif.cmd_addr = '0; cif.cmd_wdata = '0;
    sif_a.cmd_valid = 1'b0; sif_a.cmd_we = 1'b0; sif_a.cmd_addr = '0; sif_a.cmd_wdata = '0;
    sif_b.cmd_valid = 1'b0; sif_b.cmd_we = 1'b0; sif_b.cmd_addr = '0; sif_b.cmd_wdata = '0;
    for (int i = 0; i < 16; i++) pool[i] = AW'($urandom);
    pool[0]  = '0;
    pool[15] = '1;

    repeat (3) @(negedge clk);
    check("rst_ceb", ceb, 1);
    check("rst_web", web, 1);
    check("rst_oeb", oeb, 1);
    check("rst_addr", saddr, 0);
    check("rst_data_oe", dut.data_oe_q, 0);
    check("rst_rdata", cif.rdata, 0);
    check("rst_rdata_valid", cif.rdata_valid, 0);
    check("rst_cmd_ready", cif.cmd_ready, 1);
    @(posedge clk); #1;
    reset = 1'b0;

    // Basic write / read
    issue(1'b1, 18'h00010, 16'h1234, 1'b0);
    issue(1'b0, 18'h00010, 16'h0000, 1'b0);
    drain();

    // Address extremes
    issue(1'b1, 18'h3FFFF, 16'hBEEF, 1'b0);
    issue(1'b1, 18'h00000, 16'h0001, 1'b0);
    issue(1'b0, 18'h3FFFF, 16'h0000, 1'b0);
    issue(1'b0, 18'h00000, 16'h0000, 1'b0);
    drain();

    // cmd_valid held across four back-to-back writes, then four back-to-back reads
    for (int i = 0; i < 4; i++) issue(1'b1, AW'(18'h100 + i), DW'($urandom), i != 3);
    for (int i = 0; i < 4; i++) issue(1'b0, AW'(18'h100 + i), 16'h0000, i != 3);
    drain();

    // Write immediately followed by read of the same address
    issue(1'b1, 18'h0002A, 16'hC3C3, 1'b1);
    issue(1'b0, 18'h0002A, 16'h0000, 1'b0);
    drain();

    // Random traffic over a small address pool
    for (int i = 0; i < 80; i++)
      issue(1'($urandom_range(0, 1)), pool[$urandom_range(0, 15)], DW'($urandom), 1'($urandom_range(0, 1)));
    cif.cmd_valid = 1'b0;
    drain();

    // Reset asserted while web is low; a command presented during reset must be ignored
    issue(1'b1, 18'h00555, 16'hA5A5, 1'b0);
    n = 0;
    while (web && n < 20) begin @(negedge clk); n++; end
    check("web_low_before_reset", web, 0);
    #1;
    reset = 1'b1;
    cif.cmd_valid = 1'b1; cif.cmd_we = 1'b0; cif.cmd_addr = 18'h00555;
    #1;
    check("midrst_ceb", ceb, 1);
    check("midrst_web", web, 1);
    check("midrst_oeb", oeb, 1);
    check("midrst_data_oe", dut.data_oe_q, 0);
    check("midrst_rdata", cif.rdata, 0);
    ref_mem.delete(int'(18'h00555));
    unknown[int'(18'h00555)] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_hold_ready", cif.cmd_ready, 1);
    check("rst_hold_ceb", ceb, 1);
    check("rst_hold_no_rvalid", cif.rdata_valid, 0);
    cif.cmd_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", cif.cmd_ready, 1);
    check("post_rst_oeb", oeb, 1);
    @(posedge clk); #1;
    issue(1'b0, 18'h00555, 16'h0000, 1'b0);
    issue(1'b1, 18'h00555, 16'h0F0F, 1'b0);
    issue(1'b0, 18'h00555, 16'h0000, 1'b0);
    issue(1'b0, 18'h00010, 16'h0000, 1'b0);
    drain();

    // Timing sweep: WR=1/RD=4 and WR=4/RD=1
    for (int s = 0; s < 2; s++) begin
      sweep_op(1'(s), 1'b1, 18'h00ABC, 16'h7777);
      sweep_op(1'(s), 1'b0, 18'h00ABC, 16'h0000);
      sweep_op(1'(s), 1'b0, 18'h3FFFF, 16'h0000);
      sweep_op(1'(s), 1'b1, 18'h00000, 16'h1111);
    end

    repeat (5) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
